// File: rtl/riscv_enc_pkg.sv
// Shared types and constants for the RV32I immediate-path encoder.
// Immediate limits are signed byte offsets for each instruction format.
package riscv_enc_pkg;

  typedef enum logic [1:0] {
    FMT_I = 2'd0,
    FMT_S = 2'd1,
    FMT_B = 2'd2,
    FMT_J = 2'd3
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam int IMM_IS_MIN = -2048;
  localparam int IMM_IS_MAX = 2047;
  localparam int IMM_B_MIN  = -4096;
  localparam int IMM_B_MAX  = 4094;
  localparam int IMM_J_MIN  = -1048576;
  localparam int IMM_J_MAX  = 1048574;

endpackage

// File: rtl/imm_field_pack.sv
// Combinational packer: format + decoded fields -> 32-bit instruction word.
// An unrepresentable immediate yields the canonical NOP and err=1.
module imm_field_pack
  import riscv_enc_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        err
);

  logic signed [31:0] simm;
  logic [31:0]        packed_word;
  logic               in_range;

  assign simm = imm;

  always_comb begin
    packed_word = NOP;
    in_range    = 1'b0;
    case (fmt)
      FMT_I: begin
        packed_word = {imm[11:0], rs1, funct3, rd, opcode};
        in_range    = (simm >= IMM_IS_MIN) && (simm <= IMM_IS_MAX);
      end
      FMT_S: begin
        packed_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        in_range    = (simm >= IMM_IS_MIN) && (simm <= IMM_IS_MAX);
      end
      FMT_B: begin
        packed_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        in_range    = (simm >= IMM_B_MIN) && (simm <= IMM_B_MAX) && !imm[0];
      end
      FMT_J: begin
        packed_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        in_range    = (simm >= IMM_J_MIN) && (simm <= IMM_J_MAX) && !imm[0];
      end
      default: begin
        packed_word = NOP;
        in_range    = 1'b0;
      end
    endcase
  end

  assign inst = in_range ? packed_word : NOP;
  assign err  = !in_range;

endmodule

// File: rtl/inst_encoder.sv
// Two-stage valid/ready encoder: stage 1 holds the packed word and range result,
// stage 2 is the output register with a wrapping byte address and error counter.
module inst_encoder
  import riscv_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256,
  parameter int          CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_addr,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH - 1));

  logic        s1_v;
  logic [31:0] s1_inst;
  logic        s1_err;
  logic [31:0] pk_inst;
  logic        pk_err;
  logic        s2_ready;
  logic        out_fire;

  imm_field_pack u_pack (
    .fmt    (fmt_e'(in_fmt)),
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .imm    (in_imm),
    .inst   (pk_inst),
    .err    (pk_err)
  );

  // Handshake: a beat moves on any rising edge where valid && ready. A stage may
  // load whenever it is empty or its contents leave on the same edge; a loaded
  // output beat never changes until out_ready takes it.
  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_v || s2_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v    <= 1'b0;
      s1_inst <= '0;
      s1_err  <= 1'b0;
    end else if (clear) begin
      s1_v <= 1'b0;
    end else if (in_ready) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_inst <= pk_inst;
        s1_err  <= pk_err;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_err   <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_v;
      if (s1_v) begin
        out_inst <= s1_inst;
        out_err  <= s1_err;
      end
    end
  end

  // Address and error count follow completed output handshakes; clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_addr <= BASE_ADDR;
      err_cnt  <= '0;
    end else if (clear) begin
      out_addr <= BASE_ADDR;
      err_cnt  <= '0;
    end else if (out_fire) begin
      out_addr <= (out_addr == LAST_ADDR) ? BASE_ADDR : out_addr + 32'd4;
      if (out_err && (err_cnt != {CNT_W{1'b1}}))
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder (DEPTH=4 so address wrap is reachable quickly).
module tb_inst_encoder;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_cnt;

  int total;
  int bad;

  inst_encoder #(.BASE_ADDR(32'h0000_0000), .DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_fields(input logic [1:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [31:0] imm);
    in_fmt    = fmt;
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_imm    = imm;
  endtask

  // Driver: one request with out_ready=1; reports the output beat and latency in cycles.
  task automatic send_one(input logic [1:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [31:0] imm, output logic [31:0] inst,
                          output logic [31:0] addr, output logic err, output int lat);
    int wait_cnt;
    @(negedge clk);
    out_ready = 1'b1;
    drive_fields(fmt, op, rd, rs1, rs2, f3, imm);
    in_valid = 1'b1;
    wait_cnt = 0;
    #1;
    while (!in_ready && wait_cnt < 20) begin
      @(negedge clk);
      #1;
      wait_cnt++;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    inst = out_inst;
    addr = out_addr;
    err  = out_err;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive_fields(2'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++;
    if (out_inst !== 32'h0) begin bad++; $display("FAIL reset_out_inst got=%h want=00000000", out_inst); end
    total++;
    if (out_addr !== 32'h0) begin bad++; $display("FAIL reset_out_addr got=%h want=00000000", out_addr); end
    total++;
    if (out_err !== 1'b0 || err_cnt !== 8'd0) begin
      bad++; $display("FAIL reset_err got=%b/%0d want=0/0", out_err, err_cnt);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_i_type();
    logic [31:0] inst, addr;
    logic        err;
    int          lat;
    send_one(2'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'hFFFF_FFFF, inst, addr, err, lat);
    total++;
    if (inst !== 32'hFFF0_0093) begin bad++; $display("FAIL i_inst got=%h want=fff00093", inst); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL i_err got=%b want=0", err); end
    total++;
    if (addr !== 32'h0) begin bad++; $display("FAIL i_addr got=%h want=00000000", addr); end
    total++;
    if (lat != 2) begin bad++; $display("FAIL i_latency got=%0d want=2", lat); end
  endtask

  task automatic test_s_b_type();
    logic [31:0] inst, addr;
    logic        err;
    int          lat;
    send_one(2'd1, 7'b0100011, 5'd0, 5'd3, 5'd2, 3'b010, 32'd8, inst, addr, err, lat);
    total++;
    if (inst !== 32'h0021_A423 || err !== 1'b0) begin
      bad++; $display("FAIL s_inst got=%h/%b want=0021a423/0", inst, err);
    end
    total++;
    if (addr !== 32'h4) begin bad++; $display("FAIL s_addr got=%h want=00000004", addr); end
    send_one(2'd2, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 32'hFFFF_FFFC, inst, addr, err, lat);
    total++;
    if (inst !== 32'hFE00_0EE3 || err !== 1'b0) begin
      bad++; $display("FAIL b_inst got=%h/%b want=fe000ee3/0", inst, err);
    end
  endtask

  task automatic test_j_type();
    logic [31:0] inst, addr;
    logic        err;
    int          lat;
    send_one(2'd3, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 32'h0000_0800, inst, addr, err, lat);
    total++;
    if (inst !== 32'h0010_00EF || err !== 1'b0) begin
      bad++; $display("FAIL j_pos_inst got=%h/%b want=001000ef/0", inst, err);
    end
    total++;
    if (addr !== 32'hC) begin bad++; $display("FAIL j_addr got=%h want=0000000c", addr); end
    send_one(2'd3, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 32'hFFFF_FFFE, inst, addr, err, lat);
    total++;
    if (inst !== 32'hFFFF_F0EF || err !== 1'b0) begin
      bad++; $display("FAIL j_neg_inst got=%h/%b want=fffff0ef/0", inst, err);
    end
    total++;
    if (addr !== 32'h0) begin bad++; $display("FAIL j_wrap_addr got=%h want=00000000", addr); end
  endtask

  task automatic test_errors();
    logic [31:0] inst, addr;
    logic        err;
    int          lat;
    do_clear();
    send_one(2'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'd2048, inst, addr, err, lat);
    total++;
    if (inst !== 32'h0000_0013 || err !== 1'b1) begin
      bad++; $display("FAIL err_i got=%h/%b want=00000013/1", inst, err);
    end
    send_one(2'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 32'd3, inst, addr, err, lat);
    total++;
    if (inst !== 32'h0000_0013 || err !== 1'b1) begin
      bad++; $display("FAIL err_b got=%h/%b want=00000013/1", inst, err);
    end
    send_one(2'd3, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 32'h0010_0000, inst, addr, err, lat);
    total++;
    if (inst !== 32'h0000_0013 || err !== 1'b1) begin
      bad++; $display("FAIL err_j got=%h/%b want=00000013/1", inst, err);
    end
    total++;
    if (err_cnt !== 8'd3) begin bad++; $display("FAIL err_cnt got=%0d want=3", err_cnt); end
    // an in-range boundary value must not count as an error
    send_one(2'd0, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 32'hFFFF_F800, inst, addr, err, lat);
    total++;
    if (inst !== 32'h8000_0113 || err !== 1'b0 || err_cnt !== 8'd3) begin
      bad++; $display("FAIL i_min got=%h/%b/%0d want=80000113/0/3", inst, err, err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] e_inst, e_addr;
    int          sent, got;
    do_clear();
    exp_q      = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193,
                   32'h0040_0213, 32'h0050_0293, 32'h0060_0313};
    exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h4};
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      in_valid = (sent < 6);
      drive_fields(2'd0, 7'b0010011, 5'(sent + 1), 5'd0, 5'd0, 3'b000, 32'(sent + 1));
      out_ready = !(c >= 2 && c <= 6);
      #1;
      if (c == 2) begin
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_in_ready_full got=%b want=0", in_ready); end
      end
      if (c == 6) begin
        total++;
        if (out_valid !== 1'b1 || out_inst !== 32'h0010_0093 || out_addr !== 32'h0) begin
          bad++; $display("FAIL b2b_hold got=%b/%h/%h want=1/00100093/00000000", out_valid, out_inst, out_addr);
        end
      end
      if (out_valid && out_ready) begin
        e_inst = exp_q.pop_front();
        e_addr = exp_addr_q.pop_front();
        total++;
        if (out_inst !== e_inst || out_addr !== e_addr) begin
          bad++; $display("FAIL b2b_word%0d got=%h@%h want=%h@%h", got, out_inst, out_addr, e_inst, e_addr);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++;
    if (got != 6) begin bad++; $display("FAIL b2b_count got=%0d want=6", got); end
  endtask

  task automatic test_reset_clear_midstream();
    logic [31:0] inst, addr;
    logic        err;
    int          lat;
    send_one(2'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'd5, inst, addr, err, lat);
    // async reset while a word sits in stage 1
    @(negedge clk);
    drive_fields(2'd0, 7'b0010011, 5'd7, 5'd0, 5'd0, 3'b000, 32'd7);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_addr !== 32'h0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL midreset got=%b/%h/%b want=0/00000000/1", out_valid, out_addr, in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_drop got=%b want=0", out_valid); end
    send_one(2'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'd1, inst, addr, err, lat);
    total++;
    if (addr !== 32'h0 || inst !== 32'h0010_0093) begin
      bad++; $display("FAIL post_reset_word got=%h@%h want=00100093@00000000", inst, addr);
    end
    // clear with an errored word offered on the output in the same cycle
    send_one(2'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'd4096, inst, addr, err, lat);
    @(negedge clk);
    out_ready = 1'b0;
    drive_fields(2'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'd9999);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive_fields(2'd0, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'b000, 32'd3);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    clear     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_addr !== 32'h0 || err_cnt !== 8'd0) begin
      bad++; $display("FAIL clear got=%b/%h/%0d want=0/00000000/0", out_valid, out_addr, err_cnt);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL clear_drop got=%b want=0", out_valid); end
    send_one(2'd1, 7'b0100011, 5'd0, 5'd3, 5'd2, 3'b010, 32'd8, inst, addr, err, lat);
    total++;
    if (addr !== 32'h0 || inst !== 32'h0021_A423) begin
      bad++; $display("FAIL post_clear_word got=%h@%h want=0021a423@00000000", inst, addr);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_i_type();
    test_s_b_type();
    test_j_type();
    test_errors();
    test_back_to_back();
    test_reset_clear_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
